gbe_rx_status_collector: RTL
============================

Name: gbe_rx_status_collector

Overview:
Upstream feeder for the gbe1 rx status software register. Monitors the 10GbE core receive interface in the user_clk domain and tracks frame boundaries with a small FSM. Maintains good-frame, bad-frame and overrun counters plus sticky flags, and packs them into one registered 32-bit word that drives the register's user_data_in. A software-driven clear input resets the statistics.

Parameters:
PKT_CNT_SAT, 0, good-packet counter: 0 = wrap at 2^16, 1 = saturate at 0xFFFF
LINK_SYNC_STAGES, 2, flip-flop stages on the asynchronous link_up input (2..4)

Ports:
user_clk  in  1  sole clock, 10GbE user clock
user_rst_n  in  1  asynchronous active-low reset
rx_valid  in  1  rx data beat valid
rx_eof  in  1  last beat of frame; qualified by rx_valid
rx_bad_frame  in  1  frame CRC/length error; sampled only on rx_valid & rx_eof
rx_overrun  in  1  core rx buffer overrun, level
link_up  in  1  PHY link status, asynchronous to user_clk
clr  in  1  statistics clear, level from software register
user_data_out  out  32  packed status word, to the status register's user_data_in

Behaviour:
- Reset: all counters, sticky flags and synchronizer flops go to 0; FSM enters IDLE; user_data_out = 0x00000000.
- Word layout:
  - [31] link_up (synchronized)
  - [30] overrun_sticky
  - [29] bad_sticky
  - [28] in_frame (FSM != IDLE)
  - [27:24] overrun_cnt, 4-bit saturating
  - [23:16] bad_cnt, 8-bit saturating
  - [15:0] pkt_cnt
- FSM states and transitions:
  - IDLE:
    - rx_valid & !rx_eof -> IN_FRAME.
    - rx_valid & rx_eof -> single-beat frame, counted immediately; stay in IDLE.
  - IN_FRAME:
    - rx_valid & rx_eof -> frame end -> IDLE.
    - Overrun rising edge -> DISCARD.
  - DISCARD: rx_valid & rx_eof -> IDLE; this frame is counted in neither pkt_cnt nor bad_cnt.
- Frame end (not in DISCARD):
  - rx_bad_frame = 1 -> bad_cnt += 1 (saturating at 0xFF); bad_sticky set.
  - rx_bad_frame = 0 -> pkt_cnt += 1 (wrap or saturate per PKT_CNT_SAT).
- Overrun:
  - A rising edge of rx_overrun, registered in user_clk, increments overrun_cnt (saturating at 0xF) and sets overrun_sticky.
  - A held level counts once.
  - An overrun edge on the same beat as the IN_FRAME eof: the frame counts normally, overrun is counted, next state is IDLE.
- Clear:
  - The rising edge of clr, registered once internally, zeros pkt_cnt, bad_cnt, overrun_cnt and both sticky flags on the following edge.
  - A held clr clears only once.
  - FSM state and link_up are not affected.
  - Clear and a counting event in the same cycle: clear wins and the event is dropped.
- Latency:
  - Counters and user_data_out update on the clock edge that samples the qualifying beat, so the word is visible one cycle after the input beat.
  - link_up reaches bit 31 after LINK_SYNC_STAGES+1 edges.
- rx_eof and rx_bad_frame without rx_valid are ignored.
- rx_valid beats in IDLE that are not eof start a frame; no protocol check is made for a missing start.
- Reset asserted mid-frame: immediate return to IDLE with all counts zero.
- Reset release is the integrator's responsibility to synchronize; it is not synchronized internally.

Optional Feature:
GBE_RX_STATUS_FRAME_LEN_EN
- Defined:
  - Adds output port frame_len_max [15:0].
  - A beat counter runs within each frame, saturating at 0xFFFF.
  - At a good frame end, frame_len_max = max(frame_len_max, beats in the frame including the eof beat).
  - Bad and DISCARD frames do not update it.
  - Cleared by reset and by a clr edge.
- Undefined: the port, beat counter and comparator are absent; all other behaviour is identical.

Decomposition:
- Package gbe_rx_status_pkg holds:
  - FSM state enum (IDLE, IN_FRAME, DISCARD)
  - bit-position and field-width constants for the status word
  - counter saturation constants
- One sub-module, gbe_rx_status_sync: LINK_SYNC_STAGES-deep single-bit synchronizer with async active-low reset, used for link_up.

Test Plan:
- Reset, then link_up = 1 held -> user_data_out = 0x80000000 after 3 edges; all counts 0.
- Three 4-beat good frames, then one 1-beat frame -> pkt_cnt = 4, word = 0x80000004, in_frame = 0 at the end.
- Good frame, then a frame with rx_bad_frame on the eof beat -> pkt_cnt = 1, bad_cnt = 1, bit 29 = 1; 300 more bad frames -> bad_cnt = 0xFF.
- rx_overrun pulsed on beat 2 of a 5-beat frame, held 10 cycles -> overrun_cnt = 1, bit 30 = 1, frame not counted; the following good frame counts, pkt_cnt = 1.
- clr raised on the same cycle as a good eof while pkt_cnt = 7 -> all count fields and sticky bits 0, bits 31 and 28 preserved; clr held 20 cycles causes no further clears; the next frame counts 1.
- PKT_CNT_SAT = 1 with pkt_cnt preloaded via 65535 frames -> the next frame leaves 0xFFFF. With GBE_RX_STATUS_FRAME_LEN_EN: frames of 3, 9 and 5 beats -> frame_len_max = 9.

Source files
------------

// File: rtl/gbe_rx_status_pkg.sv
// Shared types and constants for the gbe1 rx status collector: FSM states, status-word layout, saturation limits.
// Pure definitions; no logic, latency or backpressure.
package gbe_rx_status_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IN_FRAME = 2'd1,
      ST_DISCARD  = 2'd2
   } rx_state_e;

   localparam int unsigned STATUS_W       = 32;
   localparam int unsigned LINK_BIT       = 31;
   localparam int unsigned OVR_STICKY_BIT = 30;
   localparam int unsigned BAD_STICKY_BIT = 29;
   localparam int unsigned IN_FRAME_BIT   = 28;
   localparam int unsigned OVR_CNT_LSB    = 24;
   localparam int unsigned OVR_CNT_W      = 4;
   localparam int unsigned BAD_CNT_LSB    = 16;
   localparam int unsigned BAD_CNT_W      = 8;
   localparam int unsigned PKT_CNT_LSB    = 0;
   localparam int unsigned PKT_CNT_W      = 16;
   localparam int unsigned FRAME_LEN_W    = 16;

   localparam logic [OVR_CNT_W-1:0]   OVR_CNT_MAX   = '1;
   localparam logic [BAD_CNT_W-1:0]   BAD_CNT_MAX   = '1;
   localparam logic [PKT_CNT_W-1:0]   PKT_CNT_MAX   = '1;
   localparam logic [FRAME_LEN_W-1:0] FRAME_LEN_MAX = '1;

endpackage

// File: rtl/gbe_rx_status_sync.sv
// Multi-stage single-bit synchronizer for asynchronous level inputs (link_up).
// Output lags the input by STAGES clock edges; no backpressure.
module gbe_rx_status_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gbe_rx_status_collector.sv
// gbe1 rx status word builder: frame FSM, good/bad/overrun counters, sticky flags; word valid 1 cycle after the beat.
// No backpressure (pure monitor). Optional GBE_RX_STATUS_FRAME_LEN_EN adds the frame_len_max output.
module gbe_rx_status_collector
   import gbe_rx_status_pkg::*;
#(
   parameter bit          PKT_CNT_SAT      = 1'b0,
   parameter int unsigned LINK_SYNC_STAGES = 2
) (
   input  logic                  user_clk,
   input  logic                  user_rst_n,
   input  logic                  rx_valid,
   input  logic                  rx_eof,
   input  logic                  rx_bad_frame,
   input  logic                  rx_overrun,
   input  logic                  link_up,
   input  logic                  clr,
`ifdef GBE_RX_STATUS_FRAME_LEN_EN
   output logic [FRAME_LEN_W-1:0] frame_len_max,
`endif
   output logic [STATUS_W-1:0]   user_data_out
);

   rx_state_e              state_q;
   logic                   in_frame_q;
   logic                   link_sync;
   logic                   link_q;
   logic                   ovr_prev_q;
   logic                   clr_prev_q;
   logic [PKT_CNT_W-1:0]   pkt_cnt_q,  pkt_cnt_d;
   logic [BAD_CNT_W-1:0]   bad_cnt_q,  bad_cnt_d;
   logic [OVR_CNT_W-1:0]   ovr_cnt_q,  ovr_cnt_d;
   logic                   ovr_sticky_q, ovr_sticky_d;
   logic                   bad_sticky_q, bad_sticky_d;

   logic ovr_rise, clr_rise, eof_beat, frame_done, good_done, bad_done;

   assign ovr_rise   = rx_overrun & ~ovr_prev_q;
   assign clr_rise   = clr & ~clr_prev_q;
   assign eof_beat   = rx_valid & rx_eof;
   assign frame_done = eof_beat & (state_q != ST_DISCARD);
   assign good_done  = frame_done & ~rx_bad_frame;
   assign bad_done   = frame_done & rx_bad_frame;

   gbe_rx_status_sync #(
      .STAGES (LINK_SYNC_STAGES)
   ) u_link_sync (
      .clk   (user_clk),
      .rst_n (user_rst_n),
      .d     (link_up),
      .q     (link_sync)
   );

   // in_frame_q tracks the state being entered so the word bit lines up with the counters.
   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         state_q    <= ST_IDLE;
         in_frame_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_valid && !rx_eof) begin
                  state_q    <= ST_IN_FRAME;
                  in_frame_q <= 1'b1;
               end
            end
            ST_IN_FRAME: begin
               if (eof_beat) begin
                  state_q    <= ST_IDLE;
                  in_frame_q <= 1'b0;
               end else if (ovr_rise) begin
                  state_q    <= ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (eof_beat) begin
                  state_q    <= ST_IDLE;
                  in_frame_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               in_frame_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      pkt_cnt_d    = pkt_cnt_q;
      bad_cnt_d    = bad_cnt_q;
      ovr_cnt_d    = ovr_cnt_q;
      ovr_sticky_d = ovr_sticky_q;
      bad_sticky_d = bad_sticky_q;
      if (clr_rise) begin
         pkt_cnt_d    = '0;
         bad_cnt_d    = '0;
         ovr_cnt_d    = '0;
         ovr_sticky_d = 1'b0;
         bad_sticky_d = 1'b0;
      end else begin
         if (good_done && !(PKT_CNT_SAT && pkt_cnt_q == PKT_CNT_MAX)) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
         end
         if (bad_done) begin
            if (bad_cnt_q != BAD_CNT_MAX) bad_cnt_d = bad_cnt_q + 1'b1;
            bad_sticky_d = 1'b1;
         end
         if (ovr_rise) begin
            if (ovr_cnt_q != OVR_CNT_MAX) ovr_cnt_d = ovr_cnt_q + 1'b1;
            ovr_sticky_d = 1'b1;
         end
      end
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         link_q       <= 1'b0;
         ovr_prev_q   <= 1'b0;
         clr_prev_q   <= 1'b0;
         pkt_cnt_q    <= '0;
         bad_cnt_q    <= '0;
         ovr_cnt_q    <= '0;
         ovr_sticky_q <= 1'b0;
         bad_sticky_q <= 1'b0;
      end else begin
         link_q       <= link_sync;
         ovr_prev_q   <= rx_overrun;
         clr_prev_q   <= clr;
         pkt_cnt_q    <= pkt_cnt_d;
         bad_cnt_q    <= bad_cnt_d;
         ovr_cnt_q    <= ovr_cnt_d;
         ovr_sticky_q <= ovr_sticky_d;
         bad_sticky_q <= bad_sticky_d;
      end
   end

`ifdef GBE_RX_STATUS_FRAME_LEN_EN
   logic [FRAME_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [FRAME_LEN_W-1:0] flen_max_q, flen_max_d;
   logic [FRAME_LEN_W-1:0] cur_len;

   // Length of the frame ending on this beat, eof beat included.
   assign cur_len = (state_q == ST_IDLE) ? FRAME_LEN_W'(1) :
                    (beat_cnt_q == FRAME_LEN_MAX) ? FRAME_LEN_MAX : beat_cnt_q + 1'b1;

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      flen_max_d = flen_max_q;
      if (rx_valid) beat_cnt_d = cur_len;
      if (clr_rise) begin
         flen_max_d = '0;
      end else if (good_done && cur_len > flen_max_q) begin
         flen_max_d = cur_len;
      end
   end

   always_ff @(posedge user_clk or negedge user_rst_n) begin
      if (!user_rst_n) begin
         beat_cnt_q <= '0;
         flen_max_q <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         flen_max_q <= flen_max_d;
      end
   end

   assign frame_len_max = flen_max_q;
`endif

   always_comb begin
      user_data_out                                = '0;
      user_data_out[LINK_BIT]                      = link_q;
      user_data_out[OVR_STICKY_BIT]                = ovr_sticky_q;
      user_data_out[BAD_STICKY_BIT]                = bad_sticky_q;
      user_data_out[IN_FRAME_BIT]                  = in_frame_q;
      user_data_out[OVR_CNT_LSB +: OVR_CNT_W]      = ovr_cnt_q;
      user_data_out[BAD_CNT_LSB +: BAD_CNT_W]      = bad_cnt_q;
      user_data_out[PKT_CNT_LSB +: PKT_CNT_W]      = pkt_cnt_q;
   end

endmodule
